// File: rtl/uart_rx_ext.sv
// Oversampling UART receiver: LSB-first payload, optional parity, one or two stop bits.
// Define UART_RX_MAJORITY_EN to take each bit value as a 2-of-3 vote around mid-bit.
module uart_rx_ext #(
  parameter int DATA_WIDTH        = 8,
  parameter int PRESCALE_WIDTH    = 6,
  parameter int BIT_COUNTER_WIDTH = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP2,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err,
  output logic                      busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  localparam logic [BIT_COUNTER_WIDTH-1:0] DATA_LAST = BIT_COUNTER_WIDTH'(DATA_WIDTH - 1);

  logic                         sync1, rx_s;
  logic [2:0]                   state;
  logic [PRESCALE_WIDTH-1:0]    edge_cnt, p_l;
  logic [BIT_COUNTER_WIDTH-1:0] bit_cnt;
  logic                         par_en_l, par_typ_l, stop2_l;
  logic [DATA_WIDTH-1:0]        shreg;
  logic                         par_bad, stp_bad;

  logic [PRESCALE_WIDTH-1:0]    sample_cnt;
  logic                         sample_pt, wrap, bit_val, stop_last;

`ifdef UART_RX_MAJORITY_EN
  // rx_s history: [1] is the value at sample_cnt-2, [0] at sample_cnt-1.
  logic [1:0] hist;

  always_ff @(posedge CLK) begin
    if (!RST) hist <= 2'b11;
    else      hist <= {hist[0], rx_s};
  end

  always_comb begin
    sample_cnt = (p_l >> 1) + 1'b1;
    bit_val    = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
  end
`else
  always_comb begin
    sample_cnt = p_l >> 1;
    bit_val    = rx_s;
  end
`endif

  always_comb begin
    sample_pt = (edge_cnt == sample_cnt);
    wrap      = (edge_cnt == p_l - 1'b1);
    stop_last = (bit_cnt == {{(BIT_COUNTER_WIDTH-1){1'b0}}, stop2_l});
  end

  assign busy = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      // NOTE: synchroniser flops reset to the idle line level so that leaving reset is not mistaken for a start edge.
      sync1      <= 1'b1;
      rx_s       <= 1'b1;
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      p_l        <= '0;
      par_en_l   <= 1'b0;
      par_typ_l  <= 1'b0;
      stop2_l    <= 1'b0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      stp_bad    <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      sync1 <= RX_IN;
      rx_s  <= sync1;
      // NOTE: pulses default low every cycle; only the DONE branch raises them, which makes them exactly one cycle wide.
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (state != IDLE) edge_cnt <= wrap ? '0 : edge_cnt + 1'b1;

      case (state)
        IDLE: begin
          // The cycle in which rx_s is first seen low is edge count 0 of the start bit.
          if (!rx_s) begin
            state     <= START;
            edge_cnt  <= PRESCALE_WIDTH'(1);
            bit_cnt   <= '0;
            p_l       <= Prescale;
            par_en_l  <= PAR_EN;
            par_typ_l <= PAR_TYP;
            stop2_l   <= STOP2;
            par_bad   <= 1'b0;
            stp_bad   <= 1'b0;
          end
        end
        START: begin
          if (sample_pt && bit_val) begin
            state    <= IDLE;
            edge_cnt <= '0;
          end else if (wrap) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (sample_pt) shreg <= {bit_val, shreg[DATA_WIDTH-1:1]};
          if (wrap) begin
            if (bit_cnt == DATA_LAST) begin
              state   <= par_en_l ? PARITY : STOP;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (sample_pt) par_bad <= (bit_val != (^shreg ^ par_typ_l));
          if (wrap) begin
            state   <= STOP;
            bit_cnt <= '0;
          end
        end
        STOP: begin
          if (wrap) bit_cnt <= bit_cnt + 1'b1;
          // The final stop bit ends at its sample point so a following start edge is not missed.
          if (sample_pt) begin
            if (!bit_val) stp_bad <= 1'b1;
            if (stop_last) begin
              state    <= DONE;
              edge_cnt <= '0;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          edge_cnt <= '0;
          par_err  <= par_bad;
          stp_err  <= stp_bad;
          if (!par_bad && !stp_bad) begin
            data_valid <= 1'b1;
            P_DATA     <= shreg;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Self-checking bench for uart_rx_ext: frame-level model of pulse timing, busy and P_DATA,
// compared every cycle, plus literal checks of payloads, pulse counts and pulse spacing.
module tb_uart_rx_ext;

  localparam int DW = 8;
  localparam int PW = 6;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_in;
  logic [PW-1:0] prescale;
  logic          par_en, par_typ, stop2;
  logic [DW-1:0] p_data;
  logic          data_valid, par_err, stp_err, busy;

  uart_rx_ext #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW), .BIT_COUNTER_WIDTH(5)) dut (
    .CLK(clk), .RST(rst), .RX_IN(rx_in), .Prescale(prescale),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
    .P_DATA(p_data), .data_valid(data_valid), .par_err(par_err),
    .stp_err(stp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // One record per receiver episode: a frame, a rejected false start, or an aborted frame.
  typedef struct {
    int            busy_from;
    int            busy_to;
    int            pulse;
    bit            dv;
    bit            pe;
    bit            se;
    logic [DW-1:0] data;
  } exp_t;

  exp_t model_q[$];
  bit   chk_en = 1'b0;

  int dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
  int dv_cycles[$];

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin dv_cnt++; dv_cycles.push_back(cyc); end
    if (par_err === 1'b1) pe_cnt++;
    if (stp_err === 1'b1) se_cnt++;
  end

  always @(negedge clk) begin
    logic          e_dv, e_pe, e_se, e_busy;
    logic [DW-1:0] e_pd;
    int            best;
    if (chk_en) begin
      e_dv = 1'b0; e_pe = 1'b0; e_se = 1'b0; e_busy = 1'b0;
      e_pd = '0; best = -1;
      foreach (model_q[i]) begin
        if (cyc >= model_q[i].busy_from && cyc < model_q[i].busy_to) e_busy = 1'b1;
        if (cyc == model_q[i].pulse) begin
          e_dv = model_q[i].dv; e_pe = model_q[i].pe; e_se = model_q[i].se;
        end
        if (model_q[i].dv && model_q[i].pulse <= cyc && model_q[i].pulse > best) begin
          best = model_q[i].pulse;
          e_pd = model_q[i].data;
        end
      end
      check("data_valid", data_valid, e_dv);
      check("par_err", par_err, e_pe);
      check("stp_err", stp_err, e_se);
      check("busy", busy, e_busy);
      check("P_DATA", p_data, e_pd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A frame's outcome comes from parity/stop rules; its pulse lands floor(P/2)+2 cycles
  // after the last stop bit starts at rx_s, which is 2 cycles behind RX_IN.
  task automatic expect_frame(input int start, input int p, input logic [DW-1:0] data,
                              input bit pen, input bit ptyp, input bit pbit,
                              input bit st2, input bit sa, input bit sb);
    exp_t e, g;
    int   hs, nbits;
    bit   last_stop;
    hs        = p / 2 + MAJ;
    nbits     = 1 + DW + (pen ? 1 : 0) + (st2 ? 2 : 1);
    last_stop = st2 ? sb : sa;
    e.pe      = pen && ((($countones(data) + pbit) % 2) != (ptyp ? 1 : 0));
    e.se      = !sa || (st2 && !sb);
    e.dv      = !e.pe && !e.se;
    e.data    = data;
    e.pulse     = start + (nbits - 1) * p + 4 + hs;
    e.busy_from = start + 3;
    e.busy_to   = e.pulse;
    model_q.push_back(e);
    // A low final stop bit is still on rx_s when IDLE returns: it reads as a false start.
    if (!last_stop && (4 + hs <= p + 1)) begin
      g.pe = 1'b0; g.se = 1'b0; g.dv = 1'b0; g.data = '0;
      g.pulse     = -1000;
      g.busy_from = e.pulse + 1;
      g.busy_to   = e.pulse + 1 + hs;
      model_q.push_back(g);
    end
  endtask

  task automatic expect_glitch(input int start, input int p);
    exp_t g;
    g.pe = 1'b0; g.se = 1'b0; g.dv = 1'b0; g.data = '0;
    g.pulse     = -1000;
    g.busy_from = start + 3;
    g.busy_to   = start + 3 + p / 2 + MAJ;
    model_q.push_back(g);
  endtask

  task automatic send_line(input logic [19:0] bits, input int n, input int p,
                           input int spike, input bit midchg);
    for (int i = 0; i < n; i++) begin
      rx_in = bits[i];
      if (i == spike) begin
        repeat (p / 2) tick();
        rx_in = 1'b0;
        tick();
        rx_in = bits[i];
        repeat (p - p / 2 - 1) tick();
      end else begin
        repeat (p) tick();
      end
      if (midchg && i == 2) begin
        prescale = prescale + PW'(4);
        par_en   = ~par_en;
        stop2    = ~stop2;
      end
    end
    rx_in = 1'b1;
  endtask

  task automatic build(input logic [DW-1:0] data, input bit pen, input bit pbit,
                       input bit st2, input bit sa, input bit sb,
                       output logic [19:0] bits, output int n);
    bits    = '1;
    bits[0] = 1'b0;
    for (int k = 0; k < DW; k++) bits[1 + k] = data[k];
    n = 1 + DW;
    if (pen) begin bits[n] = pbit; n++; end
    bits[n] = sa; n++;
    if (st2) begin bits[n] = sb; n++; end
  endtask

  task automatic do_frame(input int p, input logic [DW-1:0] data, input bit pen,
                          input bit ptyp, input bit pbit, input bit st2,
                          input bit sa, input bit sb, input int spike, input bit midchg);
    logic [19:0] bits;
    int          n;
    build(data, pen, pbit, st2, sa, sb, bits, n);
    prescale = PW'(p); par_en = pen; par_typ = ptyp; stop2 = st2;
    expect_frame(cyc, p, data, pen, ptyp, pbit, st2, sa, sb);
    send_line(bits, n, p, spike, midchg);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] bits;
    int          n, start;
    exp_t        a;

    rst = 1'b0; rx_in = 1'b1; prescale = PW'(8);
    par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
    repeat (3) tick();
    check("reset P_DATA", p_data, 0);
    check("reset data_valid", data_valid, 0);
    check("reset par_err", par_err, 0);
    check("reset stp_err", stp_err, 0);
    check("reset busy", busy, 0);
    rst = 1'b1;
    tick();
    chk_en = 1'b1;

    // 0x69, even parity bit 0, one stop bit: good frame
    do_frame(8, 8'h69, 1, 0, 0, 0, 1, 1, -1, 0);
    repeat (20) tick();
    check("good 0x69 P_DATA", p_data, 8'h69);
    check("good 0x69 dv count", dv_cnt, 1);

    // same frame, parity bit flipped
    do_frame(8, 8'h69, 1, 0, 1, 0, 1, 1, -1, 0);
    repeat (20) tick();
    check("parity err count", pe_cnt, 1);
    check("parity err keeps P_DATA", p_data, 8'h69);
    check("parity err no dv", dv_cnt, 1);

    // 0xA5, no parity, two stop bits, second one low
    do_frame(8, 8'hA5, 0, 0, 0, 1, 1, 0, -1, 0);
    repeat (30) tick();
    check("stop err count", se_cnt, 1);
    check("stop err no dv", dv_cnt, 1);

    // same frame with good stop bits; config is disturbed mid-frame
    do_frame(8, 8'hA5, 0, 0, 0, 1, 1, 1, -1, 1);
    repeat (20) tick();
    check("good 0xA5 P_DATA", p_data, 8'hA5);
    check("good 0xA5 dv count", dv_cnt, 2);

    // back-to-back frames, no idle gap
    do_frame(8, 8'h96, 0, 0, 0, 0, 1, 1, -1, 0);
    do_frame(8, 8'h33, 0, 0, 0, 0, 1, 1, -1, 0);
    repeat (20) tick();
    check("b2b dv count", dv_cnt, 4);
    check("b2b pulse spacing", dv_cycles[3] - dv_cycles[2], 80);
    check("b2b P_DATA", p_data, 8'h33);

    // 2-cycle false start
    prescale = PW'(8);
    expect_glitch(cyc, 8);
    rx_in = 1'b0;
    repeat (2) tick();
    rx_in = 1'b1;
    repeat (20) tick();
    check("glitch no dv", dv_cnt, 4);
    check("glitch keeps P_DATA", p_data, 8'h33);

    // odd prescale, odd parity: 0xC3 has four ones so the parity bit is 1
    do_frame(5, 8'hC3, 1, 1, 1, 0, 1, 1, -1, 0);
    repeat (20) tick();
    check("P=5 odd parity P_DATA", p_data, 8'hC3);
    check("P=5 dv count", dv_cnt, 5);

    // both errors at once: 0x01 odd parity wants 0, send 1; stop bit low
    do_frame(8, 8'h01, 1, 1, 1, 0, 0, 1, -1, 0);
    repeat (30) tick();
    check("both err par count", pe_cnt, 2);
    check("both err stop count", se_cnt, 2);
    check("both err keeps P_DATA", p_data, 8'hC3);

`ifdef UART_RX_MAJORITY_EN
    // 1-cycle low spike at the sample point of data bit 1 (a 1) is outvoted
    do_frame(8, 8'h5A, 0, 0, 0, 0, 1, 1, 2, 0);
    repeat (20) tick();
    check("majority spike P_DATA", p_data, 8'h5A);
    check("majority spike dv count", dv_cnt, 6);
`endif

    // P=16 frame aborted by reset after four data bits
    build(8'h5A, 0, 0, 0, 1, 1, bits, n);
    prescale = PW'(16); par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
    start = cyc;
    a.pe = 1'b0; a.se = 1'b0; a.dv = 1'b0; a.data = '0; a.pulse = -1000;
    a.busy_from = start + 3; a.busy_to = 1 << 30;
    model_q.push_back(a);
    send_line(bits, 5, 16, -1, 0);
    chk_en = 1'b0;
    rst = 1'b0;
    tick();
    check("mid reset P_DATA", p_data, 0);
    check("mid reset data_valid", data_valid, 0);
    check("mid reset par_err", par_err, 0);
    check("mid reset stp_err", stp_err, 0);
    check("mid reset busy", busy, 0);
    rst = 1'b1;
    model_q.delete();
    tick();
    chk_en = 1'b1;
    repeat (4) tick();

    do_frame(16, 8'h5A, 0, 0, 0, 0, 1, 1, -1, 0);
    repeat (30) tick();
    check("after reset P_DATA", p_data, 8'h5A);
    check("after reset dv count", dv_cnt, 6 + MAJ);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
